// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: word width, NOP encoding,
// fetch FSM states and the registered fetch/decode payload.
package instruction_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_out_t;
endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter register; load enable and next value come from the fetch FSM.
module instruction_fetch_pc_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clock) begin
    if (!reset)    pc <= RESET_VECTOR;
    else if (load) pc <= next_pc;
  end
endmodule

// File: rtl/instruction_fetch.sv
// RV32 fetch stage: drives the rom address from the PC, registers the rom word
// into a valid/ready stage toward decode, handles redirects and halts on faults.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00000000,
  parameter logic [XLEN-1:0] ROM_BYTES    = 32'h00000400,
  parameter logic [XLEN-1:0] NOP_WORD     = NOP_INSN
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] rom_address,
  input  logic [XLEN-1:0] rom_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            fault
);
  fetch_state_t    state;
  fetch_out_t      stage;
  logic [XLEN-1:0] pc, pc_next;
  logic            pc_load, redirect_bad, load_slot, pc_oob;

  instruction_fetch_pc_register #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
    .clock   (clock),
    .reset   (reset),
    .load    (pc_load),
    .next_pc (pc_next),
    .pc      (pc)
  );

  assign rom_address     = pc;
  assign out_instruction = stage.instruction;
  assign out_pc          = stage.pc;
  assign out_pc_plus4    = stage.pc_plus4;

  always_comb begin
    redirect_bad = redirect_valid &&
                   (redirect_target[1:0] != 2'b00 || redirect_target >= ROM_BYTES);
    load_slot    = !out_valid || out_ready;
    pc_oob       = pc >= ROM_BYTES;
    pc_load      = 1'b0;
    pc_next      = pc + 32'd4;
    if (state == RUN) begin
      if (redirect_valid && !redirect_bad) begin
        pc_load = 1'b1;
        pc_next = redirect_target;
      end else if (!redirect_valid && load_slot && !pc_oob) begin
        pc_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= BOOT;
      out_valid         <= 1'b0;
      stage.instruction <= NOP_WORD;
      stage.pc          <= '0;
      stage.pc_plus4    <= 32'd4;
      fault             <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect_bad) begin
            fault             <= 1'b1;
            out_valid         <= 1'b0;
            stage.instruction <= NOP_WORD;
            state             <= HALT;
          end else if (redirect_valid) begin
            // flush: the held word is dropped even if decode is ready this cycle
            out_valid         <= 1'b0;
            stage.instruction <= NOP_WORD;
          end else if (load_slot) begin
            if (pc_oob) begin
              fault             <= 1'b1;
              out_valid         <= 1'b0;
              stage.instruction <= NOP_WORD;
              state             <= HALT;
            end else begin
              stage.instruction <= rom_data;
              stage.pc          <= pc;
              stage.pc_plus4    <= pc + 32'd4;
              out_valid         <= 1'b1;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          fault     <= 1'b1;
          state     <= HALT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed table, hand-written corner sequences,
// then randomized traffic checked against a behavioural model.
module tb_instruction_fetch;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rom_address, rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid, out_ready;
  logic [31:0] out_instruction, out_pc, out_pc_plus4;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock(clock), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .fault(fault)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a < 32'h400) ? 32'hA0000000 + a / 4 : 32'hDEADBEEF;
  endfunction

  assign rom_data = rom_word(rom_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic rdy, input logic rv, input logic [31:0] rt);
    reset = r; out_ready = rdy; redirect_valid = rv; redirect_target = rt;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string name, input logic v, input logic [31:0] addr, input logic f);
    chk({name, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({name, ".addr"},  rom_address, addr);
    chk({name, ".fault"}, {31'b0, fault}, {31'b0, f});
  endtask

  task automatic chk_out(input string name, input logic [31:0] ins, input logic [31:0] pc);
    chk({name, ".instr"}, out_instruction, ins);
    chk({name, ".pc"},    out_pc, pc);
    chk({name, ".pc4"},   out_pc_plus4, pc + 32'd4);
  endtask

  typedef struct {
    logic rst, rdy, rv; logic [31:0] rt;
    logic e_valid; logic [31:0] e_instr, e_pc, e_pc4, e_addr; logic e_fault;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(input logic rst, rdy, rv, input logic [31:0] rt,
                              input logic v, input logic [31:0] ins, pc, pc4, addr);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.rv = rv; t.rt = rt;
    t.e_valid = v; t.e_instr = ins; t.e_pc = pc; t.e_pc4 = pc4; t.e_addr = addr; t.e_fault = 1'b0;
    return t;
  endfunction

  // behavioural reference model
  bit m_boot, m_halt, m_valid, m_fault;
  logic [31:0] m_pc, m_instr, m_opc;

  task automatic model_step(input logic rst, rdy, rv, input logic [31:0] rt);
    if (!rst) begin
      m_boot = 1; m_halt = 0; m_valid = 0; m_fault = 0;
      m_pc = 0; m_instr = 32'h13; m_opc = 0;
    end else if (m_boot) m_boot = 0;
    else if (m_halt) m_valid = 0;
    else if (rv && (rt % 4 != 0 || rt >= 32'h400)) begin
      m_fault = 1; m_valid = 0; m_halt = 1;
    end else if (rv) begin
      m_pc = rt; m_valid = 0; m_instr = 32'h13;
    end else if (!m_valid || rdy) begin
      if (m_pc >= 32'h400) begin
        m_fault = 1; m_valid = 0; m_halt = 1;
      end else begin
        m_instr = rom_word(m_pc); m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end
    end
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

    // reset, stream, stall at out_pc=8, redirect while stalled
    tbl[0]  = mk(0, 0, 0, 0,      0, 32'h13,       0,      4,      0);
    tbl[1]  = mk(0, 1, 1, 32'h40, 0, 32'h13,       0,      4,      0);
    tbl[2]  = mk(1, 1, 0, 0,      0, 32'h13,       0,      4,      0);
    tbl[3]  = mk(1, 1, 0, 0,      1, 32'hA0000000, 0,      4,      4);
    tbl[4]  = mk(1, 1, 0, 0,      1, 32'hA0000001, 4,      8,      8);
    tbl[5]  = mk(1, 1, 0, 0,      1, 32'hA0000002, 8,      32'hC,  32'hC);
    tbl[6]  = mk(1, 0, 0, 0,      1, 32'hA0000002, 8,      32'hC,  32'hC);
    tbl[7]  = mk(1, 0, 0, 0,      1, 32'hA0000002, 8,      32'hC,  32'hC);
    tbl[8]  = mk(1, 0, 0, 0,      1, 32'hA0000002, 8,      32'hC,  32'hC);
    tbl[9]  = mk(1, 1, 0, 0,      1, 32'hA0000003, 32'hC,  32'h10, 32'h10);
    tbl[10] = mk(1, 0, 1, 32'h100,0, 32'h13,       32'hC,  32'h10, 32'h100);
    tbl[11] = mk(1, 0, 0, 0,      1, 32'hA0000040, 32'h100,32'h104,32'h104);
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rt);
      chk($sformatf("tbl%0d.valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d.instr", i), out_instruction, tbl[i].e_instr);
      chk($sformatf("tbl%0d.pc", i),    out_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.pc4", i),   out_pc_plus4, tbl[i].e_pc4);
      chk($sformatf("tbl%0d.addr", i),  rom_address, tbl[i].e_addr);
      chk($sformatf("tbl%0d.fault", i), {31'b0, fault}, {31'b0, tbl[i].e_fault});
    end

    // misaligned redirect halts; HALT ignores redirects and holds the PC
    tick(0, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    tick(1, 0, 1, 32'h102);
    chk_state("misalign", 0, 32'h4, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1, 1'($urandom), 1, 32'h40);
      chk_state($sformatf("halt%0d", i), 0, 32'h4, 1);
    end

    // redirect exactly to ROM_BYTES is out of range
    tick(0, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    chk_state("pre400", 1, 32'h4, 0);
    tick(1, 1, 1, 32'h400);
    chk_state("redir400", 0, 32'h4, 1);

    // sequential run-off at the top of the rom
    tick(0, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    tick(1, 1, 1, 32'h3FC);
    chk_state("to3fc", 0, 32'h3FC, 0);
    tick(1, 1, 0, 0);
    chk_state("last", 1, 32'h400, 0);
    chk_out("last", 32'hA00000FF, 32'h3FC);
    tick(1, 1, 0, 0);
    chk_state("runoff", 0, 32'h400, 1);

    // reset in the middle of a stall
    tick(0, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 0, 0, 0);
    chk_state("stall", 1, 32'h4, 0);
    tick(0, 0, 0, 0);
    chk_state("midrst", 0, 32'h0, 0);
    chk("midrst.instr", out_instruction, 32'h13);
    tick(1, 1, 0, 0);
    chk_state("reboot", 0, 32'h0, 0);
    tick(1, 1, 0, 0);
    chk_state("resume", 1, 32'h4, 0);
    chk_out("resume", 32'hA0000000, 32'h0);

    // randomized traffic vs model
    tick(0, 0, 0, 0);
    model_step(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, rdy, rv;
      logic [31:0] rt;
      r   = !(($urandom % 200 == 0) || (m_halt && $urandom % 8 == 0));
      rdy = ($urandom % 3) != 0;
      rv  = ($urandom % 10) == 0;
      case ($urandom % 8)
        0:       rt = $urandom;
        1:       rt = ($urandom_range(0, 255) * 4) | 32'($urandom_range(1, 3));
        2:       rt = 32'h3F0 + 4 * $urandom_range(0, 3);
        default: rt = $urandom_range(0, 255) * 4;
      endcase
      tick(r, rdy, rv, rt);
      model_step(r, rdy, rv, rt);
      chk_state($sformatf("rnd%0d", i), m_valid, m_pc, m_fault);
      if (m_valid) chk_out($sformatf("rnd%0d", i), m_instr, m_opc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
